// File: rtl/aq_load_seq.sv
// Load sequencer for a bank of async-load flops: holds ld_val stable around an
// ld_en pulse (setup/pulse/hold), then reads the bank back and flags mismatches.
module aq_load_seq #(
    parameter int WIDTH = 8,
    parameter int SETUP = 2,
    parameter int PULSE = 3,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_val,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic             ld_en,
    output logic [WIDTH-1:0] ld_val,
    input  logic [WIDTH-1:0] q_in
);

    localparam int MAX_LEN = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                             : ((PULSE > HOLD) ? PULSE : HOLD);
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_CHECK
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nx;
    logic [WIDTH-1:0] q_cap;
    logic           accept;
    logic           mismatch;

    assign accept   = req_valid && req_ready;
    assign mismatch = (q_cap != ld_val);

    // Each timed phase loads its length minus one and counts down to zero.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_SETUP;
                    cnt_nx   = CW'(SETUP - 1);
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nx = S_PULSE;
                    cnt_nx   = CW'(PULSE - 1);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    state_nx = S_HOLD;
                    cnt_nx   = CW'(HOLD - 1);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_nx = S_CHECK;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_CHECK: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are flops decoded from the next state, so they line up with the
    // state they describe and ld_en cannot glitch.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            ld_en     <= 1'b0;
            ld_val    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
            q_cap     <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            req_ready <= (state_nx == S_IDLE);
            ld_en     <= (state_nx == S_PULSE);
            done      <= (state_nx == S_CHECK);
            err       <= (state_nx == S_CHECK) && mismatch;
            if (accept) begin
                ld_val <= req_val;
            end
            // Sample the bank on the edge ending the pulse, ld_en still high.
            if (state == S_PULSE && cnt == '0) begin
                q_cap <= q_in;
            end
            if (state_nx == S_CHECK && mismatch && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_aq_load_seq.sv
// Directed bench for aq_load_seq with a behavioural async-load register bank
// that can be forced to read back zero.
module tb_aq_load_seq;

    logic       clk = 1'b0;
    logic       arst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_val;
    logic       done;
    logic       err;
    logic [7:0] err_cnt;
    logic       ld_en;
    logic [7:0] ld_val;
    logic [7:0] q_in;
    logic [7:0] bank = 8'h00;
    logic       stuck = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    aq_load_seq dut (
        .clk       (clk),
        .arst      (arst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_val   (req_val),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt),
        .ld_en     (ld_en),
        .ld_val    (ld_val),
        .q_in      (q_in)
    );

    always @(posedge clk or posedge ld_en) begin
        if (ld_en) bank <= ld_val;
    end

    assign q_in = stuck ? 8'h00 : bank;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in cycle 1 after an accept; walks cycles 1..9 and ends in cycle 9.
    task automatic applyStimulus(input logic [7:0] v, input logic [7:0] alt, input logic exp_err);
        for (int n = 1; n <= 9; n++) begin
            if (n == 2) req_val = alt;
            checkOutput($sformatf("ld_en@c%0d", n), 32'(ld_en), 32'(n >= 3 && n <= 5));
            checkOutput($sformatf("done@c%0d", n), 32'(done), 32'(n == 8));
            checkOutput($sformatf("err@c%0d", n), 32'(err), 32'((n == 8) ? exp_err : 1'b0));
            checkOutput($sformatf("req_ready@c%0d", n), 32'(req_ready), 32'(n == 9));
            checkOutput($sformatf("ld_val@c%0d", n), 32'(ld_val), 32'(v));
            if (n < 9) step();
        end
    endtask

    initial begin
        arst      = 1'b1;
        req_valid = 1'b1;
        req_val   = 8'h77;
        #2;
        checkOutput("rst_ld_en", 32'(ld_en), 32'd0);
        checkOutput("rst_ld_val", 32'(ld_val), 32'h00);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        step();
        checkOutput("rst_no_accept_ld_val", 32'(ld_val), 32'h00);
        checkOutput("rst_no_accept_ready", 32'(req_ready), 32'd1);
        #2;
        arst      = 1'b0;
        req_valid = 1'b0;
        step();

        $display("[TB] basic load 0xA5");
        req_valid = 1'b1;
        req_val   = 8'hA5;
        checkOutput("idle_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        applyStimulus(8'hA5, 8'hA5, 1'b0);
        checkOutput("err_cnt_after_a5", 32'(err_cnt), 32'd0);

        $display("[TB] stuck bank, load 0xFF");
        stuck     = 1'b1;
        req_valid = 1'b1;
        req_val   = 8'hFF;
        step();
        req_valid = 1'b0;
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        checkOutput("err_cnt_after_ff", 32'(err_cnt), 32'd1);
        stuck = 1'b0;

        $display("[TB] back-to-back 0x11 then 0x22");
        req_valid = 1'b1;
        req_val   = 8'h11;
        step();
        applyStimulus(8'h11, 8'h22, 1'b0);
        step();
        req_valid = 1'b0;
        applyStimulus(8'h22, 8'h22, 1'b0);
        checkOutput("err_cnt_after_b2b", 32'(err_cnt), 32'd1);

        $display("[TB] req_val changes mid-load");
        req_valid = 1'b1;
        req_val   = 8'hA5;
        step();
        req_valid = 1'b0;
        applyStimulus(8'hA5, 8'h3C, 1'b0);

        $display("[TB] reset during pulse");
        req_valid = 1'b1;
        req_val   = 8'h5A;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        checkOutput("pre_rst_ld_en", 32'(ld_en), 32'd1);
        #2;
        arst = 1'b1;
        #1;
        checkOutput("async_ld_en", 32'(ld_en), 32'd0);
        checkOutput("async_ld_val", 32'(ld_val), 32'h00);
        checkOutput("async_ready", 32'(req_ready), 32'd1);
        checkOutput("async_done", 32'(done), 32'd0);
        req_valid = 1'b1;
        req_val   = 8'hC3;
        step();
        checkOutput("held_rst_ld_val", 32'(ld_val), 32'h00);
        checkOutput("held_rst_done", 32'(done), 32'd0);
        checkOutput("held_rst_ld_en", 32'(ld_en), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        step();
        req_valid = 1'b0;
        applyStimulus(8'hC3, 8'hC3, 1'b0);
        checkOutput("err_cnt_cleared", 32'(err_cnt), 32'd0);

        $display("[TB] 260 mismatching loads");
        stuck     = 1'b1;
        req_valid = 1'b1;
        req_val   = 8'hFF;
        for (int k = 1; k <= 260; k++) begin
            for (int c = 0; c < 9; c++) step();
            if (k == 254) checkOutput("sat_k254", 32'(err_cnt), 32'd254);
            if (k == 255) checkOutput("sat_k255", 32'(err_cnt), 32'd255);
        end
        req_valid = 1'b0;
        checkOutput("sat_k260", 32'(err_cnt), 32'd255);
        step();
        step();
        checkOutput("sat_idle_ready", 32'(req_ready), 32'd1);
        checkOutput("sat_final", 32'(err_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
